// File: rtl/noc_client_pkg.sv
// Shared types, packet field offsets, FSM states and LFSR step for the NoC client node.
package noc_client_pkg;

  localparam int COORD_W_DEF = 2;
  localparam int PAY_W_DEF   = 8;

  typedef logic [COORD_W_DEF-1:0] coord_t;

  // Field offsets for the default geometry; the node derives its own from its parameters.
  localparam int SY_LSB = PAY_W_DEF;
  localparam int SX_LSB = PAY_W_DEF + COORD_W_DEF;
  localparam int DY_LSB = PAY_W_DEF + 2 * COORD_W_DEF;
  localparam int DX_LSB = PAY_W_DEF + 3 * COORD_W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/noc_client_node_lfsr.sv
// 16-bit Galois LFSR: loads seed on reset, steps once per cycle when advance is high.
module noc_lfsr16
  import noc_client_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= seed;
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/noc_client_node.sv
// Mesh client node: pseudo-random traffic generator plus checking sink.
// Optional NOC_CLIENT_LATENCY_EN timestamps payloads and adds lat_sum/lat_max outputs.
module noc_client_node
  import noc_client_pkg::*;
#(
  parameter int          COORD_W  = 2,
  parameter int          PAY_W    = 8,
  localparam int         PKT_W    = 4 * COORD_W + PAY_W,
  parameter int          X_ADDR   = 0,
  parameter int          Y_ADDR   = 0,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          GAP      = 2,
  parameter int          MAX_PKTS = 0,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [PKT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic [PKT_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] err_count,
  output logic             done
`ifdef NOC_CLIENT_LATENCY_EN
  ,
  output logic [CNT_W+PAY_W-1:0] lat_sum,
  output logic [PAY_W-1:0]       lat_max
`endif
);

  localparam int L_DY = PAY_W + 2 * COORD_W;
  localparam int L_DX = PAY_W + 3 * COORD_W;

  localparam logic [COORD_W-1:0] SELF_X   = COORD_W'(X_ADDR);
  localparam logic [COORD_W-1:0] SELF_Y   = COORD_W'(Y_ADDR);
  localparam logic [15:0]        SEED_MIX = SEED ^ 16'({SELF_X, SELF_Y});
  // An all-zero LFSR would lock up, so that seed is replaced.
  localparam logic [15:0]        SEED_EFF = (SEED_MIX == 16'h0000) ? 16'h0001 : SEED_MIX;

  state_t           state;
  logic [15:0]      lfsr;
  logic [15:0]      gap_cnt;
  logic [COORD_W-1:0] cand_x, cand_y;
  logic [PAY_W-1:0] payload;
  logic             self_hit;
  logic             last_pkt;
  logic             rx_fire;
  logic             misroute;
  logic             unused_bits;

  noc_lfsr16 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (state == noc_client_pkg::GEN),
    .seed    (SEED_EFF),
    .state   (lfsr)
  );

  assign cand_x   = lfsr[2*COORD_W-1:COORD_W];
  assign cand_y   = lfsr[COORD_W-1:0];
  assign self_hit = (cand_x == SELF_X) && (cand_y == SELF_Y);
  assign last_pkt = (MAX_PKTS != 0) &&
                    (({1'b0, tx_count} + (CNT_W+1)'(1)) == (CNT_W+1)'(MAX_PKTS));

`ifdef NOC_CLIENT_LATENCY_EN
  logic [PAY_W-1:0]       ts;
  logic [PAY_W-1:0]       lat;
  logic [CNT_W+PAY_W:0]   sum_ext;

  always_ff @(posedge clk) begin
    if (reset) ts <= '0;
    else       ts <= ts + PAY_W'(1);
  end

  assign payload = ts;
  assign lat     = ts - in_data[PAY_W-1:0];
  assign sum_ext = {1'b0, lat_sum} + (CNT_W+PAY_W+1)'(lat);
`else
  assign payload = lfsr[15:16-PAY_W];
`endif

  assign unused_bits = ^{lfsr, in_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      tx_count  <= '0;
      done      <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (enable && !done) state <= GEN;
        GEN: begin
          if (!self_hit) begin
            out_data  <= {cand_x, cand_y, SELF_X, SELF_Y, payload};
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            tx_count  <= (&tx_count) ? tx_count : tx_count + CNT_W'(1);
            if (last_pkt) begin
              done  <= 1'b1;
              state <= IDLE;
            end else if (GAP == 0) begin
              state <= GEN;
            end else begin
              gap_cnt <= 16'(GAP - 1);
              state   <= noc_client_pkg::GAP;
            end
          end
        end
        noc_client_pkg::GAP: begin
          if (gap_cnt == 16'd0) state <= enable ? GEN : IDLE;
          else                  gap_cnt <= gap_cnt - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_fire  = in_valid && in_ready;
  assign misroute = (in_data[L_DX +: COORD_W] != SELF_X) ||
                    (in_data[L_DY +: COORD_W] != SELF_Y);

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready  <= 1'b0;
      rx_count  <= '0;
      err_count <= '0;
`ifdef NOC_CLIENT_LATENCY_EN
      lat_sum   <= '0;
      lat_max   <= '0;
`endif
    end else begin
      in_ready <= 1'b1;
      if (rx_fire) begin
        rx_count <= (&rx_count) ? rx_count : rx_count + CNT_W'(1);
        if (misroute) begin
          err_count <= (&err_count) ? err_count : err_count + CNT_W'(1);
        end
`ifdef NOC_CLIENT_LATENCY_EN
        else begin
          lat_sum <= sum_ext[CNT_W+PAY_W] ? '1 : sum_ext[CNT_W+PAY_W-1:0];
          if (lat > lat_max) lat_max <= lat;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_noc_client_node.sv
// Directed bench for noc_client_node at node (1,2): generator scoreboard, stall, sink counters, reset.
module tb_noc_client_node;
  import noc_client_pkg::*;

  localparam int PKT_W = 16;
  localparam int CNT_W = 16;
  localparam int PW    = 8;
  localparam int GAPC  = 3;
  localparam int MAXP  = 10;
  localparam logic [3:0] SELF_D = 4'b0110;

  logic             clk, reset, enable;
  logic [PKT_W-1:0] out_data, in_data;
  logic             out_valid, out_ready, in_valid, in_ready, done;
  logic [CNT_W-1:0] tx_count, rx_count, err_count;
`ifdef NOC_CLIENT_LATENCY_EN
  logic [CNT_W+PW-1:0] lat_sum;
  logic [PW-1:0]       lat_max;
`endif

  noc_client_node #(
    .COORD_W(2), .PAY_W(PW), .X_ADDR(1), .Y_ADDR(2), .SEED(16'hACE1),
    .GAP(GAPC), .MAX_PKTS(MAXP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_count(tx_count), .rx_count(rx_count), .err_count(err_count),
    .done(done)
`ifdef NOC_CLIENT_LATENCY_EN
    , .lat_sum(lat_sum), .lat_max(lat_max)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] m_lfsr;
  logic [15:0] exp_q[$];
  int          gens_q[$];
  int          lowcnt;
  bit          have_prev;
  int          exp_tx;

  function automatic logic [15:0] model_next(input logic [15:0] s);
    logic fb;
    fb = s[0];
    s  = s >> 1;
    if (fb) s = s ^ 16'hB400;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gen_expected(input int n);
    logic [3:0] cand;
    logic [7:0] pl;
    int g;
    for (int i = 0; i < n; i++) begin
      g = 0;
      do begin
        cand   = m_lfsr[3:0];
        pl     = m_lfsr[15:8];
        m_lfsr = model_next(m_lfsr);
        g++;
      end while (cand == SELF_D);
      exp_q.push_back({cand, SELF_D, pl});
      gens_q.push_back(g);
    end
  endtask

  task automatic step();
    logic        fire;
    logic [15:0] d, e;
    int          g;
    fire = out_valid && out_ready && !reset;
    d    = out_data;
    if (!reset && !out_valid) lowcnt++;
    @(posedge clk);
    #1;
    if (fire) begin
      exp_tx++;
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL unexpected_tx observed=%0h expected=none", d);
      end else begin
        e = exp_q.pop_front();
        g = gens_q.pop_front();
        chk("tx_data", 32'(d), 32'(e));
        chk("tx_dest_not_self", 32'(d[15:12] != SELF_D), 32'd1);
        if (have_prev) chk("gap_cycles", 32'(lowcnt), 32'(GAPC + g));
        chk("tx_count", 32'(tx_count), 32'(exp_tx));
      end
      have_prev = 1'b1;
      lowcnt    = 0;
    end
  endtask

  initial begin
    logic [15:0] seed_m;
    logic [15:0] held;
    logic [CNT_W-1:0] held_tx;
    bit found;

    reset = 1'b1; enable = 1'b0; out_ready = 1'b1; in_valid = 1'b0; in_data = '0;
    exp_tx = 0; lowcnt = 0; have_prev = 1'b0;
    repeat (3) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_tx_count",  32'(tx_count),  32'd0);
    chk("rst_rx_count",  32'(rx_count),  32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_state",     32'(dut.state), 32'(IDLE));

    seed_m = 16'hACE1 ^ 16'h0006;
    if (seed_m == 16'h0000) seed_m = 16'h0001;
    m_lfsr = seed_m;
    gen_expected(MAXP);

    enable = 1'b1; reset = 1'b0;
    step();
    chk("latency_c1", 32'(out_valid), 32'd0);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    step();
    chk("latency_c2", 32'(out_valid), 32'(gens_q[0] == 1));

    // Five well-routed and two misrouted inbound packets while the generator runs.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = (i < 5) ? {4'b0110, 4'b0000, 8'(i)} : {4'b1100, 4'b0101, 8'(i)};
      step();
    end
    in_valid = 1'b0;
    in_data  = '0;
    step();
    chk("rx_count", 32'(rx_count), 32'd7);
    chk("err_count", 32'(err_count), 32'd2);

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (out_valid && exp_tx >= 2 && exp_tx < MAXP) found = 1'b1;
      else step();
    end
    chk("stall_reached", 32'(found), 32'd1);
    held    = out_data;
    held_tx = tx_count;
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data",  32'(out_data),  32'(held));
      chk("stall_tx",    32'(tx_count),  32'(held_tx));
    end
    out_ready = 1'b1;

    for (int i = 0; i < 400 && !done; i++) step();
    chk("done", 32'(done), 32'd1);
    chk("tx_final", 32'(tx_count), 32'(MAXP));
    chk("all_pkts_seen", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("post_done_valid", 32'(out_valid), 32'd0);
    end
    chk("done_sticky", 32'(done), 32'd1);
    chk("rx_count_end", 32'(rx_count), 32'd7);
    chk("err_count_end", 32'(err_count), 32'd2);

    // Reset while a packet is held in SEND.
    reset = 1'b1;
    step();
    reset = 1'b0; out_ready = 1'b0; enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (out_valid) found = 1'b1;
      else step();
    end
    chk("send_reached", 32'(found), 32'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_tx",        32'(tx_count),  32'd0);
    chk("mid_rst_rx",        32'(rx_count),  32'd0);
    chk("mid_rst_err",       32'(err_count), 32'd0);
    chk("mid_rst_done",      32'(done),      32'd0);
    chk("mid_rst_state",     32'(dut.state), 32'(IDLE));
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
